pipeline_fetch_queue: RTL and testbench

- Parametrised fetch-to-decode buffer. Successor of the single-register fetch stage.
- Sits between instruction memory/PC logic and decode. It holds up to DEPTH fetched instruction/PC pairs with valid/ready handshakes on both sides.
- Supports per-entry kill (NOP substitution), pipeline flush, and opcode extraction.
- Absorbs decode stalls without dropping fetched instructions.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_queue_mem.sv | 39 +++
 rtl/pipeline_fetch_queue.sv | 115 +++++++++++
 tb/tb_pipeline_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Included by the fetch queue and its storage.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam int OPCODE_W = 7;
  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] instruction;
    logic [FETCH_XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry register file for the fetch queue.
// One write port, one asynchronous read port, reset to NOP / PC 0.
module fetch_queue_mem
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] winstr_i,
  input  logic [XLEN-1:0] wpc_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [XLEN-1:0] rinstr_o,
  output logic [XLEN-1:0] rpc_o
);

  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= XLEN'(NOP_INSTRUCTION);
        pc_q[i]    <= '0;
      end
    end else if (we_i) begin
      instr_q[waddr_i] <= winstr_i;
      pc_q[waddr_i]    <= wpc_i;
    end
  end

  assign rinstr_o = instr_q[raddr_i];
  assign rpc_o    = pc_q[raddr_i];

endmodule

// File: rtl/pipeline_fetch_queue.sv
// Fetch-to-decode circular queue with kill, flush and opcode output.
// Define FETCH_QUEUE_BYPASS_EN for same-cycle empty-queue bypass.
module pipeline_fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_instruction,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                in_kill,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_instruction,
  output logic [XLEN-1:0]     out_pc,
  output logic [OPCODE_W-1:0] opcode,
  output logic [CNT_W-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic            empty, full;
  logic            push, wr_en, pop_mem, byp;
  logic [XLEN-1:0] winstr;
  logic [XLEN-1:0] rinstr, rpc;

  fetch_queue_mem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wr_en),
    .waddr_i  (wr_ptr_q),
    .winstr_i (winstr),
    .wpc_i    (in_pc),
    .raddr_i  (rd_ptr_q),
    .rinstr_o (rinstr),
    .rpc_o    (rpc)
  );

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CNT_W'(DEPTH));
    in_ready = !full && !flush && !rst;
    push     = in_valid && in_ready;
    pop_mem  = !empty && out_ready && !flush;
    winstr   = in_kill ? XLEN'(NOP_INSTRUCTION) : in_instruction;
    byp      = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
    byp      = empty && in_valid && !flush && !rst;
`endif
    // A bypassed entry taken by decode never touches storage
    wr_en    = push && !(byp && out_ready);
  end

  always_comb begin
    out_valid       = !empty || byp;
    out_instruction = XLEN'(NOP_INSTRUCTION);
    out_pc          = '0;
    if (byp) begin
      out_instruction = winstr;
      out_pc          = in_pc;
    end else if (!empty) begin
      out_instruction = rinstr;
      out_pc          = rpc;
    end
  end

  assign opcode = out_instruction[OPCODE_W-1:0];
  assign count  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)   wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_mem) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_en, pop_mem})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_queue.sv
// Directed self-checking bench for pipeline_fetch_queue.
// Covers reset, ordering, wrap, kill, flush and async reset.
module tb_pipeline_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_kill, flush;
  logic [XLEN-1:0]  in_instruction, in_pc;
  logic             out_valid, out_ready;
  logic [XLEN-1:0]  out_instruction, out_pc;
  logic [6:0]       opcode;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .in_kill         (in_kill),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .opcode          (opcode),
    .count           (count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_kill = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_instruction = '0;
    in_pc = '0;
  endtask

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instruction = ins;
    in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick();
    settle();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    chk("idle_instr", out_instruction, 32'h13);
    chk("idle_opcode", {25'b0, opcode}, 32'h13);
    chk("idle_count", {29'b0, count}, 32'd0);
    chk("idle_pc", out_pc, 32'd0);
    chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

    // Single push; output only appears a cycle later
    tick();
    in_valid = 1'b1;
    in_instruction = 32'h0050_0093;
    in_pc = 32'h100;
    settle();
`ifndef FETCH_QUEUE_BYPASS_EN
    chk("lat_same_cycle", {31'b0, out_valid}, 32'd0);
`endif
    tick();
    in_valid = 1'b0;
    settle();
    chk("one_valid", {31'b0, out_valid}, 32'd1);
    chk("one_instr", out_instruction, 32'h0050_0093);
    chk("one_pc", out_pc, 32'h100);
    chk("one_opcode", {25'b0, opcode}, 32'h13);
    chk("one_count", {29'b0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    settle();
    chk("one_drained", {29'b0, count}, 32'd0);

    // Fill to full from pointer 1 so both pointers wrap
    for (int i = 0; i < 4; i++)
      push1(32'hA000_0000 + i, 32'(4 * i));
    settle();
    chk("full_count", {29'b0, count}, 32'd4);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_instruction = 32'hBAD0_0000;
    in_pc = 32'h400;
    settle();
    chk("full_no_wt", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_pc", out_pc, 32'(4 * i));
      chk("drain_instr", out_instruction, 32'hA000_0000 + i);
      tick();
      if (i == 0) begin
        settle();
        chk("ready_back", {31'b0, in_ready}, 32'd1);
      end
    end
    out_ready = 1'b0;
    settle();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // Killed entry keeps its PC
    tick();
    in_kill = 1'b1;
    push1(32'hDEAD_BEEF, 32'h20);
    in_kill = 1'b0;
    settle();
    chk("kill_valid", {31'b0, out_valid}, 32'd1);
    chk("kill_instr", out_instruction, 32'h13);
    chk("kill_pc", out_pc, 32'h20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Streaming at count=2
    push1(32'hC000_0040, 32'h40);
    push1(32'hC000_0044, 32'h44);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_pc = 32'(32'h48 + 4 * k);
      in_instruction = 32'hC000_0000 | in_pc;
      settle();
      chk("stream_pc", out_pc, 32'(32'h40 + 4 * k));
      chk("stream_cnt", {29'b0, count}, 32'd2);
      tick();
    end
    out_ready = 1'b0;
    in_pc = 32'h999;
    in_instruction = 32'h0000_0999;
    flush = 1'b1;
    settle();
    chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    idle_in();
    settle();
    chk("flush_count", {29'b0, count}, 32'd0);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_pc", out_pc, 32'd0);
    tick();
    push1(32'h0030_0113, 32'h300);
    settle();
    chk("post_flush_pc", out_pc, 32'h300);
    chk("post_flush_cnt", {29'b0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-cycle at count=3
    push1(32'h1, 32'h500);
    push1(32'h2, 32'h504);
    push1(32'h3, 32'h508);
    settle();
    chk("pre_rst_cnt", {29'b0, count}, 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_count", {29'b0, count}, 32'd0);
    chk("arst_instr", out_instruction, 32'h13);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    settle();
    chk("rst_release", {31'b0, in_ready}, 32'd1);

`ifdef FETCH_QUEUE_BYPASS_EN
    tick();
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_instruction = 32'h0070_0193;
    in_pc = 32'h700;
    settle();
    chk("byp_valid", {31'b0, out_valid}, 32'd1);
    chk("byp_pc", out_pc, 32'h700);
    chk("byp_instr", out_instruction, 32'h0070_0193);
    tick();
    idle_in();
    settle();
    chk("byp_count", {29'b0, count}, 32'd0);
    chk("byp_empty", {31'b0, out_valid}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
